// File: rtl/mio_bus_responder.sv
// mio_bus_responder: responder end of the CPU memory/IO handshake.
// Decodes the latched request address into the data RAM, the LED/switch
// port or a free-running counter, and answers with a one-cycle mio_ready.
//
// state    | meaning
// IDLE     | waiting for cpu_mio; latches the request when it arrives
// RAM_ACC  | one-cycle RAM strobe (ram_en high)
// RAM_WAIT | counting down RAM read latency, captures ram_rdata at terminal count
// IO_ACC   | one-cycle LED / counter / error access
// RESP     | mio_ready (and bus_err on unmapped access) high for one cycle
module mio_bus_responder #(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mio,
    input  logic              mem_w,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw,
    output logic [15:0]       led
);

    localparam logic [31:0] LED_ADDR = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

    typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_WAIT, IO_ACC, RESP} state_t;

    state_t      state;
    logic [31:2] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic [2:0]  wait_cnt;
    logic [31:0] counter;
    logic        sel_led;
    logic        sel_cnt;
    logic        unused_addr_bits;

    // Byte-lane bits are not used: every access is a full word.
    assign unused_addr_bits = ^cpu_addr[1:0];

    function automatic logic is_ram(input logic [31:2] a);
        return (a[31:28] == 4'h0) && ({6'b0, a[27:2]} < (32'd1 << RAM_AW));
    endfunction

    assign sel_led = (lat_addr == LED_ADDR[31:2]);
    assign sel_cnt = (lat_addr == CNT_ADDR[31:2]);

    // Free-running counter; a CPU write lands so that the following cycle
    // already shows wdata+1, keeping the count continuous across the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (state == IO_ACC && lat_we && sel_cnt) begin
            counter <= lat_wdata + 32'd1;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    // Handshake FSM with registered bus and RAM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            wait_cnt  <= '0;
            cpu_rdata <= '0;
            mio_ready <= 1'b0;
            bus_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            led       <= '0;
        end else begin
            mio_ready <= 1'b0;
            bus_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_mio) begin
                        lat_addr  <= cpu_addr[31:2];
                        lat_wdata <= cpu_wdata;
                        lat_we    <= mem_w;
                        if (is_ram(cpu_addr[31:2])) begin
                            ram_en    <= 1'b1;
                            ram_we    <= mem_w;
                            ram_addr  <= cpu_addr[RAM_AW+1:2];
                            ram_wdata <= cpu_wdata;
                            state     <= RAM_ACC;
                        end else begin
                            state <= IO_ACC;
                        end
                    end
                end
                RAM_ACC: begin
                    if (lat_we) begin
                        mio_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= 3'(RAM_LAT);
                        state    <= RAM_WAIT;
                    end
                end
                RAM_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        cpu_rdata <= ram_rdata;
                        mio_ready <= 1'b1;
                        state     <= RESP;
                    end
                end
                IO_ACC: begin
                    if (sel_led) begin
                        if (lat_we) begin
                            led <= lat_wdata[15:0];
                        end else begin
                            cpu_rdata <= {16'h0000, sw};
                        end
                    end else if (sel_cnt) begin
                        if (!lat_we) begin
                            cpu_rdata <= counter;
                        end
                    end else begin
                        cpu_rdata <= '0;
                        bus_err   <= 1'b1;
                    end
                    mio_ready <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
